// File: rtl/fm_sb_spy_buffer.sv
// Per-channel spy buffer: records a stream into a circular RAM, freezes on request,
// replays the frozen window oldest-first (once or looped) and offers a 1-cycle AXI-side read port.
module fm_sb_spy_buffer #(
    parameter int DW        = 32,
    parameter int AW        = 10,
    parameter int PB_MODE_W = 2
) (
    input  logic                 axi_clk,
    input  logic                 axi_reset_n,
    input  logic                 freeze,
    input  logic [PB_MODE_W-1:0] playback_mode,
    input  logic                 init_spy_mem,
    input  logic                 din_valid,
    input  logic [DW-1:0]        din,
    output logic                 pb_valid,
    output logic [DW-1:0]        pb_data,
    input  logic                 pb_ready,
    input  logic                 rd_en,
    input  logic [AW-1:0]        rd_addr,
    output logic                 rd_valid,
    output logic [DW-1:0]        rd_data,
    output logic [AW-1:0]        wr_ptr,
    output logic                 wrapped,
    output logic                 frozen,
    output logic                 init_busy,
    output logic                 pb_done
);
    localparam int DEPTH = 2 ** AW;

    typedef enum logic [2:0] {S_SPY, S_INIT, S_FROZEN, S_PB_ONCE, S_PB_LOOP} state_t;

    state_t        state;
    logic [DW-1:0] mem [DEPTH];
    logic          init_q;
    logic          armed;
    logic          issued_all;
    logic [AW-1:0] init_cnt;
    logic [AW-1:0] pb_addr;
    logic [AW:0]   pb_idx;

    logic          init_rise;
    logic          mode_once;
    logic          mode_loop;
    logic          mode_idle;
    logic          pb_exit;
    logic          pb_load;
    logic          pb_fire;
    logic          ram_we;
    logic [AW-1:0] ram_wa;
    logic [DW-1:0] ram_wd;
    logic [AW-1:0] pb_start;
    logic [AW:0]   pb_len;

    always_comb begin
        init_rise = init_spy_mem && !init_q;
        mode_once = (playback_mode == PB_MODE_W'(1));
        mode_loop = (playback_mode == PB_MODE_W'(2));
        mode_idle = !(mode_once || mode_loop);
        pb_start  = wrapped ? wr_ptr : '0;
        pb_len    = wrapped ? (AW+1)'(DEPTH) : {1'b0, wr_ptr};
        pb_exit   = !freeze || (state == S_PB_ONCE && !mode_once)
                            || (state == S_PB_LOOP && !mode_loop);
        pb_fire   = pb_valid && pb_ready;
        pb_load   = !issued_all && (!pb_valid || pb_ready);
        // a beat arriving together with freeze or an init request is dropped
        ram_we    = (state == S_INIT) ||
                    (state == S_SPY && !freeze && din_valid && !init_rise);
        ram_wa    = (state == S_INIT) ? init_cnt : wr_ptr;
        ram_wd    = (state == S_INIT) ? '0 : din;
    end

    always_ff @(posedge axi_clk) begin
        if (ram_we) begin
            mem[ram_wa] <= ram_wd;
        end
    end

    // AXI-side read stage: read-before-write, so a colliding write returns old data
    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= mem[rd_addr];
            end
        end
    end

    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            state      <= S_SPY;
            wr_ptr     <= '0;
            wrapped    <= 1'b0;
            frozen     <= 1'b0;
            init_busy  <= 1'b0;
            pb_done    <= 1'b0;
            pb_valid   <= 1'b0;
            pb_data    <= '0;
            armed      <= 1'b1;
            init_q     <= 1'b0;
            init_cnt   <= '0;
            pb_addr    <= '0;
            pb_idx     <= '0;
            issued_all <= 1'b0;
        end else begin
            init_q  <= init_spy_mem;
            pb_done <= 1'b0;
            if (mode_idle) begin
                armed <= 1'b1;
            end
            if (init_rise) begin
                state     <= S_INIT;
                init_cnt  <= '0;
                init_busy <= 1'b1;
                frozen    <= 1'b0;
                pb_valid  <= 1'b0;
            end else begin
                case (state)
                    S_INIT: begin
                        init_cnt <= init_cnt + 1'b1;
                        if (init_cnt == AW'(DEPTH - 1)) begin
                            state     <= S_SPY;
                            init_busy <= 1'b0;
                            wr_ptr    <= '0;
                            wrapped   <= 1'b0;
                        end
                    end
                    S_SPY: begin
                        if (freeze) begin
                            state  <= S_FROZEN;
                            frozen <= 1'b1;
                        end else if (din_valid) begin
                            wr_ptr <= wr_ptr + 1'b1;
                            if (wr_ptr == AW'(DEPTH - 1)) begin
                                wrapped <= 1'b1;
                            end
                        end
                    end
                    S_FROZEN: begin
                        if (!freeze) begin
                            state  <= S_SPY;
                            frozen <= 1'b0;
                        end else if (armed && !mode_idle && pb_len != '0) begin
                            state      <= mode_once ? S_PB_ONCE : S_PB_LOOP;
                            pb_addr    <= pb_start;
                            pb_idx     <= '0;
                            issued_all <= 1'b0;
                        end
                    end
                    S_PB_ONCE, S_PB_LOOP: begin
                        if (pb_exit) begin
                            // finish the presented beat, then leave without a done pulse
                            if (!pb_valid || pb_ready) begin
                                pb_valid <= 1'b0;
                                if (freeze) begin
                                    state <= S_FROZEN;
                                end else begin
                                    state  <= S_SPY;
                                    frozen <= 1'b0;
                                end
                            end
                        end else if (pb_load) begin
                            pb_data  <= mem[pb_addr];
                            pb_valid <= 1'b1;
                            if (pb_idx == pb_len - 1'b1) begin
                                pb_idx  <= '0;
                                pb_addr <= pb_start;
                                if (state == S_PB_ONCE) begin
                                    issued_all <= 1'b1;
                                end
                            end else begin
                                pb_idx  <= pb_idx + 1'b1;
                                pb_addr <= pb_addr + 1'b1;
                            end
                        end else if (pb_fire) begin
                            pb_valid <= 1'b0;
                            state    <= S_FROZEN;
                            pb_done  <= 1'b1;
                            armed    <= 1'b0;
                        end
                    end
                    default: state <= S_SPY;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fm_sb_spy_buffer.sv
// Bench for fm_sb_spy_buffer: random recordings checked against a history-queue model
// of the circular buffer (last DEPTH beats, oldest first).
module tb_fm_sb_spy_buffer;
    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int PMW   = 2;
    localparam int DEPTH = 16;

    logic           axi_clk = 1'b0;
    logic           axi_reset_n;
    logic           freeze;
    logic [PMW-1:0] playback_mode;
    logic           init_spy_mem;
    logic           din_valid;
    logic [DW-1:0]  din;
    logic           pb_valid;
    logic [DW-1:0]  pb_data;
    logic           pb_ready;
    logic           rd_en;
    logic [AW-1:0]  rd_addr;
    logic           rd_valid;
    logic [DW-1:0]  rd_data;
    logic [AW-1:0]  wr_ptr;
    logic           wrapped;
    logic           frozen;
    logic           init_busy;
    logic           pb_done;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] hist[$];
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] got_q[$];
    logic [DW-1:0] mem_m [DEPTH];

    fm_sb_spy_buffer #(.DW(DW), .AW(AW), .PB_MODE_W(PMW)) dut (
        .axi_clk(axi_clk), .axi_reset_n(axi_reset_n), .freeze(freeze),
        .playback_mode(playback_mode), .init_spy_mem(init_spy_mem),
        .din_valid(din_valid), .din(din), .pb_valid(pb_valid), .pb_data(pb_data),
        .pb_ready(pb_ready), .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(rd_valid),
        .rd_data(rd_data), .wr_ptr(wr_ptr), .wrapped(wrapped), .frozen(frozen),
        .init_busy(init_busy), .pb_done(pb_done)
    );

    always #5 axi_clk = ~axi_clk;

    task automatic step();
        @(posedge axi_clk);
        #1;
    endtask

    function automatic logic [AW-1:0] model_wp();
        return AW'(hist.size() % DEPTH);
    endfunction

    function automatic logic model_wrapped();
        return hist.size() >= DEPTH;
    endfunction

    function automatic void build_exp();
        int n = hist.size();
        int l = (n >= DEPTH) ? DEPTH : n;
        exp_q.delete();
        for (int i = n - l; i < n; i++) exp_q.push_back(hist[i]);
    endfunction

    task automatic spy_write(input logic [DW-1:0] v);
        logic [AW-1:0] a;
        a = model_wp();
        din_valid = 1'b1;
        din = v;
        step();
        din_valid = 1'b0;
        mem_m[a] = v;
        hist.push_back(v);
    endtask

    task automatic apply_reset();
        axi_reset_n = 1'b0;
        step();
        step();
        axi_reset_n = 1'b1;
        hist.delete();
    endtask

    // gathers accepted beats; reports data/valid changes under stall and done position
    task automatic run_pb(input int want, input int ready_pct, input int max_cyc, input bit stop_on_done,
                          output int done_cnt, output int done_at, output int stall_bad);
        logic          pv;
        logic          pr;
        logic [DW-1:0] pd;
        got_q.delete();
        done_cnt = 0;
        done_at = -1;
        stall_bad = 0;
        for (int c = 0; c < max_cyc; c++) begin
            if (got_q.size() >= want) break;
            if (stop_on_done && done_cnt != 0) break;
            pb_ready = ($urandom_range(99) < 32'(ready_pct));
            pv = pb_valid;
            pr = pb_ready;
            pd = pb_data;
            if (pv && pr) got_q.push_back(pd);
            step();
            if (pb_done) begin
                done_cnt++;
                done_at = got_q.size();
            end
            if (pv && !pr && (!pb_valid || pb_data !== pd)) stall_bad++;
        end
    endtask

    task automatic test_reset();
        axi_reset_n = 1'b0;
        step();
        checks++;
        if ({pb_valid, rd_valid, wrapped, frozen, init_busy, pb_done} !== 6'b0 || wr_ptr !== '0 || pb_data !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got flags=%b wr_ptr=%0d pb_data=%0h required all zero",
                     {pb_valid, rd_valid, wrapped, frozen, init_busy, pb_done}, wr_ptr, pb_data);
        end
        axi_reset_n = 1'b1;
        step();
        hist.delete();
    endtask

    task automatic test_spy_basic();
        for (int i = 0; i < 5; i++) spy_write(DW'(32'hA0 + i));
        checks++;
        if (wr_ptr !== model_wp() || wrapped !== model_wrapped()) begin
            errors++;
            $display("FAIL spy_ptr: got wr_ptr=%0d wrapped=%b required %0d %b", wr_ptr, wrapped, model_wp(), model_wrapped());
        end
        for (int i = 0; i < 5; i++) begin
            rd_en = 1'b1;
            rd_addr = AW'(i);
            step();
            checks++;
            if (rd_valid !== 1'b1 || rd_data !== mem_m[AW'(i)]) begin
                errors++;
                $display("FAIL spy_read[%0d]: got v=%b %0h required 1 %0h", i, rd_valid, rd_data, mem_m[AW'(i)]);
            end
        end
        rd_en = 1'b0;
        step();
        checks++;
        if (rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL rd_valid_drop: got %b required 0", rd_valid);
        end
    endtask

    task automatic test_play_once();
        int dc, da, sb, bad;
        apply_reset();
        for (int i = 0; i < 20; i++) spy_write($urandom() | 32'h1000_0000);
        freeze = 1'b1;
        step();
        checks++;
        if (frozen !== 1'b1 || wr_ptr !== model_wp() || wrapped !== 1'b1) begin
            errors++;
            $display("FAIL once_frozen: got frozen=%b wr_ptr=%0d wrapped=%b required 1 %0d 1", frozen, wr_ptr, wrapped, model_wp());
        end
        build_exp();
        pb_ready = 1'b1;
        playback_mode = 2'd1;
        step();
        checks++;
        if (pb_valid !== 1'b0) begin
            errors++;
            $display("FAIL once_latency_early: got pb_valid=%b required 0", pb_valid);
        end
        step();
        checks++;
        if (pb_valid !== 1'b1) begin
            errors++;
            $display("FAIL once_latency: got pb_valid=%b required 1", pb_valid);
        end
        run_pb(100, 100, 100, 1'b1, dc, da, sb);
        bad = 0;
        for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) if (got_q[k] !== exp_q[k]) bad++;
        checks++;
        if (got_q.size() != exp_q.size() || bad != 0) begin
            errors++;
            $display("FAIL once_data: got %0d beats %0d wrong required %0d beats", got_q.size(), bad, exp_q.size());
        end
        checks++;
        if (dc != 1 || da != DEPTH || pb_valid !== 1'b0) begin
            errors++;
            $display("FAIL once_done: got pulses=%0d at=%0d pb_valid=%b required 1 at %0d valid 0", dc, da, pb_valid, DEPTH);
        end
    endtask

    task automatic test_loop_stall();
        int dc, da, sb, bad;
        logic [DW-1:0] held;
        playback_mode = 2'd0;
        step();
        playback_mode = 2'd2;
        step();
        step();
        build_exp();
        run_pb(40, 50, 400, 1'b0, dc, da, sb);
        bad = 0;
        for (int k = 0; k < got_q.size(); k++) if (got_q[k] !== exp_q[k % exp_q.size()]) bad++;
        checks++;
        if (got_q.size() != 40 || bad != 0 || sb != 0 || dc != 0) begin
            errors++;
            $display("FAIL loop_data: got %0d beats %0d wrong stall_bad=%0d done=%0d required 40 0 0 0", got_q.size(), bad, sb, dc);
        end
        pb_ready = 1'b0;
        playback_mode = 2'd0;
        held = pb_data;
        checks++;
        if (pb_valid !== 1'b1 || held !== exp_q[40 % DEPTH]) begin
            errors++;
            $display("FAIL loop_next_beat: got v=%b %0h required 1 %0h", pb_valid, held, exp_q[40 % DEPTH]);
        end
        step();
        step();
        checks++;
        if (pb_valid !== 1'b1 || pb_data !== held) begin
            errors++;
            $display("FAIL exit_hold: got v=%b %0h required 1 %0h", pb_valid, pb_data, held);
        end
        pb_ready = 1'b1;
        step();
        step();
        checks++;
        if (pb_valid !== 1'b0 || frozen !== 1'b1 || pb_done !== 1'b0) begin
            errors++;
            $display("FAIL exit_frozen: got pb_valid=%b frozen=%b pb_done=%b required 0 1 0", pb_valid, frozen, pb_done);
        end
    endtask

    task automatic test_freeze_same_cycle();
        logic [AW-1:0] wp;
        logic [DW-1:0] v;
        freeze = 1'b0;
        step();
        wp = model_wp();
        din_valid = 1'b1;
        din = 32'h55;
        freeze = 1'b1;
        step();
        din_valid = 1'b0;
        rd_en = 1'b1;
        rd_addr = wp;
        step();
        rd_en = 1'b0;
        checks++;
        if (wr_ptr !== wp || frozen !== 1'b1 || rd_data !== mem_m[wp]) begin
            errors++;
            $display("FAIL freeze_drop: got wr_ptr=%0d frozen=%b mem=%0h required %0d 1 %0h", wr_ptr, frozen, rd_data, wp, mem_m[wp]);
        end
        freeze = 1'b0;
        step();
        v = $urandom() | 32'h1000_0000;
        rd_en = 1'b1;
        rd_addr = wp;
        spy_write(v);
        checks++;
        if (rd_data !== hist[hist.size() - 1 - DEPTH] || wr_ptr !== model_wp()) begin
            errors++;
            $display("FAIL resume_collide: got old=%0h wr_ptr=%0d required %0h %0d", rd_data, wr_ptr, hist[hist.size() - 1 - DEPTH], model_wp());
        end
        step();
        rd_en = 1'b0;
        checks++;
        if (rd_data !== v) begin
            errors++;
            $display("FAIL resume_write: got %0h required %0h", rd_data, v);
        end
    endtask

    task automatic test_once_rearm();
        int dc, da, sb, stray;
        freeze = 1'b1;
        step();
        build_exp();
        for (int r = 0; r < 2; r++) begin
            playback_mode = 2'd1;
            step();
            step();
            run_pb(100, 100, 100, 1'b1, dc, da, sb);
            checks++;
            if (got_q != exp_q || dc != 1) begin
                errors++;
                $display("FAIL rearm_play[%0d]: got %0d beats done=%0d required %0d beats done=1", r, got_q.size(), dc, exp_q.size());
            end
            stray = 0;
            for (int c = 0; c < 10; c++) begin
                step();
                if (pb_valid || pb_done) stray++;
            end
            checks++;
            if (stray != 0) begin
                errors++;
                $display("FAIL no_restart[%0d]: got %0d active cycles required 0", r, stray);
            end
            playback_mode = 2'd0;
            step();
        end
    endtask

    task automatic test_init_abort();
        int busy_cnt;
        playback_mode = 2'd2;
        step();
        step();
        checks++;
        if (pb_valid !== 1'b1) begin
            errors++;
            $display("FAIL loop_start: got pb_valid=%b required 1", pb_valid);
        end
        pb_ready = 1'b0;
        init_spy_mem = 1'b1;
        step();
        checks++;
        if (pb_valid !== 1'b0 || init_busy !== 1'b1) begin
            errors++;
            $display("FAIL init_abort: got pb_valid=%b init_busy=%b required 0 1", pb_valid, init_busy);
        end
        freeze = 1'b0;
        playback_mode = 2'd0;
        busy_cnt = 1;
        din_valid = 1'b1;
        din = 32'hDEAD_BEEF;
        step();
        if (init_busy) busy_cnt++;
        step();
        if (init_busy) busy_cnt++;
        init_spy_mem = 1'b0;
        step();
        if (init_busy) busy_cnt++;
        init_spy_mem = 1'b1;
        step();
        if (init_busy) busy_cnt++;
        din_valid = 1'b0;
        for (int c = 0; c < 60; c++) begin
            step();
            if (init_busy) busy_cnt++;
            else break;
        end
        checks++;
        if (busy_cnt != 4 + DEPTH) begin
            errors++;
            $display("FAIL init_busy_len: got %0d cycles required %0d", busy_cnt, 4 + DEPTH);
        end
        hist.delete();
        for (int i = 0; i < DEPTH; i++) mem_m[AW'(i)] = '0;
        checks++;
        if (wr_ptr !== '0 || wrapped !== 1'b0 || frozen !== 1'b0 || init_busy !== 1'b0) begin
            errors++;
            $display("FAIL init_state: got wr_ptr=%0d wrapped=%b frozen=%b busy=%b required 0 0 0 0", wr_ptr, wrapped, frozen, init_busy);
        end
        for (int i = 0; i < DEPTH; i++) begin
            rd_en = 1'b1;
            rd_addr = AW'(i);
            step();
            checks++;
            if (rd_valid !== 1'b1 || rd_data !== mem_m[AW'(i)]) begin
                errors++;
                $display("FAIL init_clear[%0d]: got v=%b %0h required 1 0", i, rd_valid, rd_data);
            end
        end
        rd_en = 1'b0;
        init_spy_mem = 1'b0;
        step();
    endtask

    task automatic test_empty();
        int stray;
        freeze = 1'b1;
        step();
        playback_mode = 2'd1;
        stray = 0;
        for (int c = 0; c < 10; c++) begin
            step();
            if (pb_valid || pb_done) stray++;
        end
        checks++;
        if (stray != 0 || frozen !== 1'b1) begin
            errors++;
            $display("FAIL empty_play: got %0d active cycles frozen=%b required 0 1", stray, frozen);
        end
        playback_mode = 2'd0;
        freeze = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        int dc, da, sb, n;
        for (int it = 0; it < 4; it++) begin
            n = int'($urandom_range(24, 1));
            for (int k = 0; k < n; k++) begin
                if ($urandom_range(3) == 0) step();
                spy_write($urandom() | 32'h1000_0000);
            end
            checks++;
            if (wr_ptr !== model_wp() || wrapped !== model_wrapped()) begin
                errors++;
                $display("FAIL rand_ptr[%0d]: got %0d %b required %0d %b", it, wr_ptr, wrapped, model_wp(), model_wrapped());
            end
            build_exp();
            freeze = 1'b1;
            step();
            playback_mode = 2'd1;
            step();
            step();
            run_pb(100, 60, 400, 1'b1, dc, da, sb);
            checks++;
            if (got_q != exp_q || dc != 1 || da != exp_q.size() || sb != 0) begin
                errors++;
                $display("FAIL rand_play[%0d]: got %0d beats done=%0d at %0d stall_bad=%0d required %0d beats", it, got_q.size(), dc, da, sb, exp_q.size());
            end
            playback_mode = 2'd0;
            freeze = 1'b0;
            step();
            step();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        axi_reset_n = 1'b0;
        freeze = 1'b0;
        playback_mode = 2'd0;
        init_spy_mem = 1'b0;
        din_valid = 1'b0;
        din = '0;
        pb_ready = 1'b0;
        rd_en = 1'b0;
        rd_addr = '0;
        for (int i = 0; i < DEPTH; i++) mem_m[AW'(i)] = '0;
        test_reset();
        test_spy_basic();
        test_play_once();
        test_loop_stall();
        test_freeze_same_cycle();
        test_once_rearm();
        test_init_abort();
        test_empty();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
